// File: rtl/fastram_dram_sequencer_if.sv
// Bus bundle between the 68020 side (master) and the fastram DRAM sequencer (slave).
// Carries the CPU strobes/attributes in and the DRAM strobes plus cycle termination out.
interface fastram_dram_sequencer_if;
  logic       AS20;
  logic       DS20;
  logic       RW20;
  logic [1:0] SIZ;
  logic [1:0] A;
  logic       ABANK;
  logic       ram_sel;
  logic [1:0] RAS;
  logic [3:0] CAS;
  logic       RAM_MUX;
  logic       RAMOE;
  logic [1:0] DSACK;
  logic       ref_ovf;

  modport master (
    output AS20, DS20, RW20, SIZ, A, ABANK, ram_sel,
    input  RAS, CAS, RAM_MUX, RAMOE, DSACK, ref_ovf
  );

  modport slave (
    input  AS20, DS20, RW20, SIZ, A, ABANK, ram_sel,
    output RAS, CAS, RAM_MUX, RAMOE, DSACK, ref_ovf
  );
endinterface

// File: rtl/fastram_dram_sequencer.sv
// Zorro fastram DRAM sequencer: RAS/CAS/address-mux timing for 68020 cycles,
// arbitrated against CAS-before-RAS refresh, with 32-bit DSACK termination.
// All DRAM/bus outputs are registered from the current state, so each pin
// follows its state by one clock.
// Optional build macro FASTRAM_WAITSTATE_EN inserts one WAIT cycle between COL
// and CASW for slower DRAM (DSACK one clock later).
module fastram_dram_sequencer #(
  parameter int unsigned REFRESH_DIV   = 218,
  parameter int unsigned PRECHARGE_CYC = 1,
  parameter int unsigned BANK_BIT      = 21
) (
  input  logic                     CLKCPU,
  input  logic                     RESET,
  fastram_dram_sequencer_if.slave  bus
);

  localparam int unsigned      DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [1:0]       PRE_LAST = 2'(PRECHARGE_CYC - 1);

  // ABANK arrives already decoded from A[BANK_BIT]; the bit must lie above the byte offset.
  if (BANK_BIT < 2 || PRECHARGE_CYC < 1 || PRECHARGE_CYC > 3 || REFRESH_DIV < 8) begin : g_bad_params
    $error("fastram_dram_sequencer: illegal parameter set");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_ROW, S_COL, S_WAIT, S_CASW, S_ACK,
    S_REF_CAS, S_REF_RAS, S_REF_HOLD, S_PRE
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       pre_q, pre_d;
  logic             abort_q, abort_d;
  logic             div_wrap, ref_req, ref_start;

  logic             cyc_rw_q, cyc_rw_d;
  logic [1:0]       cyc_siz_q, cyc_siz_d;
  logic [1:0]       cyc_a_q, cyc_a_d;
  logic             cyc_bank_q, cyc_bank_d;

  logic [1:0]       ras_q, ras_d;
  logic [3:0]       cas_q, cas_d;
  logic             mux_q, mux_d;
  logic             oe_q, oe_d;
  logic [1:0]       dsack_q, dsack_d;

  // Active-low byte-lane CAS pattern for a write of SIZ bytes starting at offset A.
  function automatic logic [3:0] write_lanes(input logic [1:0] siz, input logic [1:0] a);
    logic [3:0] lanes;
    lanes = 4'hF;
    case (siz)
      2'b01: case (a)
               2'd0: lanes = 4'b0111;
               2'd1: lanes = 4'b1011;
               2'd2: lanes = 4'b1101;
               default: lanes = 4'b1110;
             endcase
      2'b10: case (a)
               2'd0: lanes = 4'b0011;
               2'd1: lanes = 4'b1001;
               2'd2: lanes = 4'b1100;
               default: lanes = 4'b1110;
             endcase
      2'b11: case (a)
               2'd0: lanes = 4'b0001;
               2'd1: lanes = 4'b1000;
               2'd2: lanes = 4'b1100;
               default: lanes = 4'b1110;
             endcase
      default: case (a)
               2'd0: lanes = 4'b0000;
               2'd1: lanes = 4'b1000;
               2'd2: lanes = 4'b1100;
               default: lanes = 4'b1110;
             endcase
    endcase
    return lanes;
  endfunction

  // Row strobe for the latched bank, all other banks held high.
  function automatic logic [1:0] bank_ras(input logic bank);
    return bank ? 2'b01 : 2'b10;
  endfunction

  // Refresh divider and pending-request bookkeeping; a wrap that coincides with
  // a refresh start is consumed directly so the pending count is unchanged.
  always_comb begin
    div_wrap  = (div_q == DIV_LAST);
    div_d     = div_wrap ? '0 : div_q + 1'b1;
    ref_req   = (pend_q != 2'd0) || div_wrap;
    ref_start = (state_q == S_IDLE) && ref_req;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    if (div_wrap && !ref_start) begin
      if (pend_q == 2'd3) ovf_d = 1'b1;
      else                pend_d = pend_q + 2'd1;
    end else if (!div_wrap && ref_start) begin
      pend_d = pend_q - 2'd1;
    end
  end

  // Next-state logic; refresh has priority in IDLE but never interrupts a CPU cycle.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    abort_d    = abort_q;
    cyc_rw_d   = cyc_rw_q;
    cyc_siz_d  = cyc_siz_q;
    cyc_a_d    = cyc_a_q;
    cyc_bank_d = cyc_bank_q;
    case (state_q)
      S_IDLE: begin
        if (ref_req) begin
          state_d = S_REF_CAS;
        end else if (!bus.AS20 && bus.ram_sel) begin
          state_d    = S_ROW;
          abort_d    = 1'b0;
          cyc_rw_d   = bus.RW20;
          cyc_siz_d  = bus.SIZ;
          cyc_a_d    = bus.A;
          cyc_bank_d = bus.ABANK;
        end
      end
      S_ROW: begin
        abort_d = abort_q | bus.AS20;
        state_d = S_COL;
      end
      S_COL: begin
        abort_d = abort_q | bus.AS20;
`ifdef FASTRAM_WAITSTATE_EN
        state_d = S_WAIT;
`else
        state_d = S_CASW;
`endif
      end
      S_WAIT: begin
        abort_d = abort_q | bus.AS20;
        state_d = S_CASW;
      end
      S_CASW: begin
        abort_d = abort_q | bus.AS20;
        // An abandoned write must not stall forever waiting for DS20.
        if (cyc_rw_q || !bus.DS20 || bus.AS20 || abort_q) state_d = S_ACK;
      end
      S_ACK: begin
        if (bus.AS20 || abort_q) begin
          state_d = S_PRE;
          pre_d   = PRE_LAST;
        end
      end
      S_REF_CAS:  state_d = S_REF_RAS;
      S_REF_RAS:  state_d = S_REF_HOLD;
      S_REF_HOLD: begin
        state_d = S_PRE;
        pre_d   = PRE_LAST;
      end
      S_PRE: begin
        if (pre_q == 2'd0) state_d = S_IDLE;
        else               pre_d   = pre_q - 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pin values implied by the current state; registered below.
  always_comb begin
    ras_d   = 2'b11;
    cas_d   = 4'hF;
    mux_d   = 1'b0;
    oe_d    = 1'b1;
    dsack_d = 2'b11;
    case (state_q)
      S_ROW: ras_d = bank_ras(cyc_bank_q);
      S_COL, S_WAIT, S_CASW: begin
        ras_d = bank_ras(cyc_bank_q);
        mux_d = 1'b1;
      end
      S_ACK: begin
        ras_d = bank_ras(cyc_bank_q);
        mux_d = 1'b1;
        if (!abort_q) begin
          dsack_d = 2'b00;
          cas_d   = cyc_rw_q ? 4'h0 : write_lanes(cyc_siz_q, cyc_a_q);
          oe_d    = !cyc_rw_q;
        end
      end
      S_REF_CAS: cas_d = 4'h0;
      S_REF_RAS, S_REF_HOLD: begin
        cas_d = 4'h0;
        ras_d = 2'b00;
      end
      default: ;
    endcase
  end

  // Control state and registered pins, cleared by synchronous reset.
  always_ff @(posedge CLKCPU) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      pend_q  <= 2'd0;
      ovf_q   <= 1'b0;
      pre_q   <= 2'd0;
      abort_q <= 1'b0;
      ras_q   <= 2'b11;
      cas_q   <= 4'hF;
      mux_q   <= 1'b0;
      oe_q    <= 1'b1;
      dsack_q <= 2'b11;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      pre_q   <= pre_d;
      abort_q <= abort_d;
      ras_q   <= ras_d;
      cas_q   <= cas_d;
      mux_q   <= mux_d;
      oe_q    <= oe_d;
      dsack_q <= dsack_d;
    end
  end

  // Cycle attributes captured when the cycle is accepted; only read while it is active.
  always_ff @(posedge CLKCPU) begin
    cyc_rw_q   <= cyc_rw_d;
    cyc_siz_q  <= cyc_siz_d;
    cyc_a_q    <= cyc_a_d;
    cyc_bank_q <= cyc_bank_d;
  end

  assign bus.RAS     = ras_q;
  assign bus.CAS     = cas_q;
  assign bus.RAM_MUX = mux_q;
  assign bus.RAMOE   = oe_q;
  assign bus.DSACK   = dsack_q;
  assign bus.ref_ovf = ovf_q;

endmodule

// File: tb/tb_fastram_dram_sequencer.sv
// Self-checking bench for fastram_dram_sequencer (also valid with FASTRAM_WAITSTATE_EN).
// Reference model: refresh requests derived from the edge count since reset, the
// sequencer viewed as IDLE windows separated by busy intervals of known length.
module tb_fastram_dram_sequencer;

  localparam int DIV = 218;
  localparam int PRE = 1;
`ifdef FASTRAM_WAITSTATE_EN
  localparam int WS = 1;
`else
  localparam int WS = 0;
`endif

  logic clk;
  logic rst_n;
  int   ecnt;
  int   checks;
  int   errors;

  // model state
  int   m_i0;
  int   m_pend;
  bit   m_ovf;
  int   m_refs;

  fastram_dram_sequencer_if bus();

  fastram_dram_sequencer dut (
    .CLKCPU (clk),
    .RESET  (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // index of the next rising edge counted from reset release
  always @(posedge clk) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit is_wrap(input int t);
    return (t % DIV) == DIV - 1;
  endfunction

  function automatic void bump(input int t);
    if (is_wrap(t)) begin
      if (m_pend == 3) m_ovf = 1'b1;
      else             m_pend++;
    end
  endfunction

  // First IDLE edge >= s at which the CPU cycle is accepted, serving refreshes first.
  function automatic int model_start(input int s);
    int t;
    int n;
    t = m_i0;
    n = -1;
    while (n < 0) begin
      if (m_pend > 0 || is_wrap(t)) begin
        if (!is_wrap(t)) m_pend--;
        m_refs++;
        for (int u = t + 1; u <= t + 3 + PRE; u++) bump(u);
        t = t + 4 + PRE;
      end else if (t >= s) begin
        n = t;
      end else begin
        t++;
      end
    end
    return n;
  endfunction

  function automatic void model_finish(input int n, input int r);
    for (int u = n + 1; u <= r + PRE; u++) bump(u);
    m_i0 = r + 1 + PRE;
  endfunction

  // Byte lanes touched by a transfer: SIZ bytes from offset A, clipped at lane 3.
  function automatic logic [3:0] lanes_model(input logic [1:0] siz, input logic [1:0] a);
    logic [3:0] res;
    int nb;
    res = 4'hF;
    nb  = (siz == 2'b00) ? 4 : int'(siz);
    for (int k = 0; k < nb; k++) begin
      if (int'(a) + k <= 3) res[3 - (int'(a) + k)] = 1'b0;
    end
    return res;
  endfunction

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.AS20    = 1'b1;
    bus.DS20    = 1'b1;
    bus.RW20    = 1'b1;
    bus.SIZ     = 2'b00;
    bus.A       = 2'b00;
    bus.ABANK   = 1'b0;
    bus.ram_sel = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    m_i0   = 0;
    m_pend = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic run_txn(input bit rw, input logic [1:0] siz, input logic [1:0] a,
                         input bit bank, input int gap, input int dsd, input int hold);
    int s, n, aedge, seen, le, obs_refs, r;
    logic [1:0] prev_ras;
    logic [1:0] exp_ras;
    logic [3:0] exp_cas;
    prev_ras = bus.RAS;
    obs_refs = 0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      if (bus.RAS == 2'b00 && prev_ras != 2'b00) obs_refs++;
      prev_ras = bus.RAS;
    end
    s           = ecnt;
    bus.AS20    = 1'b0;
    bus.RW20    = rw;
    bus.SIZ     = siz;
    bus.A       = a;
    bus.ABANK   = bank;
    bus.ram_sel = 1'b1;
    bus.DS20    = (dsd == 0) ? 1'b0 : 1'b1;
    m_refs  = 0;
    n       = model_start(s);
    aedge   = rw ? (n + 3 + WS) : (((n + 3 + WS) > (s + dsd)) ? (n + 3 + WS) : (s + dsd));
    exp_ras = bank ? 2'b01 : 2'b10;
    exp_cas = rw ? 4'h0 : lanes_model(siz, a);
    seen    = -1;
    for (int c = 0; c < 3000 && seen < 0; c++) begin
      @(negedge clk);
      le = ecnt - 1;
      if (ecnt == s + dsd) bus.DS20 = 1'b0;
      if (bus.RAS == 2'b00 && prev_ras != 2'b00) obs_refs++;
      prev_ras = bus.RAS;
      if (le == n + 1) begin
        checks++;
        if (bus.RAS !== exp_ras) begin
          errors++;
          $display("FAIL row_ras: got %b want %b", bus.RAS, exp_ras);
        end
      end
      if (le == n + 2) begin
        checks++;
        if (bus.RAM_MUX !== 1'b1) begin
          errors++;
          $display("FAIL col_mux: got %b want 1", bus.RAM_MUX);
        end
      end
      if (bus.DSACK === 2'b00) seen = le;
    end
    checks++;
    if (seen != aedge + 1) begin
      errors++;
      $display("FAIL dsack_edge: got %0d want %0d (start %0d)", seen, aedge + 1, s);
    end
    checks++;
    if (bus.CAS !== exp_cas) begin
      errors++;
      $display("FAIL ack_cas: got %b want %b", bus.CAS, exp_cas);
    end
    checks++;
    if (bus.RAMOE !== !rw) begin
      errors++;
      $display("FAIL ack_ramoe: got %b want %b", bus.RAMOE, !rw);
    end
    checks++;
    if (obs_refs != m_refs) begin
      errors++;
      $display("FAIL refresh_count: got %0d want %0d", obs_refs, m_refs);
    end
    repeat (hold) @(negedge clk);
    checks++;
    if (bus.RAS !== exp_ras || bus.DSACK !== 2'b00) begin
      errors++;
      $display("FAIL hold_cycle: got RAS %b DSACK %b want %b 00", bus.RAS, bus.DSACK, exp_ras);
    end
    r        = ecnt;
    bus.AS20 = 1'b1;
    bus.DS20 = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.DSACK !== 2'b11 || bus.RAS !== 2'b11 || bus.CAS !== 4'hF || bus.RAMOE !== 1'b1) begin
      errors++;
      $display("FAIL precharge: got DSACK %b RAS %b CAS %b OE %b want 11 11 1111 1",
               bus.DSACK, bus.RAS, bus.CAS, bus.RAMOE);
    end
    model_finish(n, r);
    checks++;
    if (bus.ref_ovf !== m_ovf) begin
      errors++;
      $display("FAIL ref_ovf: got %b want %b", bus.ref_ovf, m_ovf);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (bus.RAS !== 2'b11)    begin errors++; $display("FAIL reset_ras: got %b want 11", bus.RAS); end
    if (bus.CAS !== 4'hF)     begin errors++; $display("FAIL reset_cas: got %b want 1111", bus.CAS); end
    if (bus.DSACK !== 2'b11)  begin errors++; $display("FAIL reset_dsack: got %b want 11", bus.DSACK); end
    if (bus.RAMOE !== 1'b1)   begin errors++; $display("FAIL reset_ramoe: got %b want 1", bus.RAMOE); end
    if (bus.RAM_MUX !== 1'b0) begin errors++; $display("FAIL reset_mux: got %b want 0", bus.RAM_MUX); end
    if (bus.ref_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.ref_ovf); end
  endtask

  task automatic test_long_read();
    do_reset();
    run_txn(1'b1, 2'b00, 2'd0, 1'b0, 2, 0, 1);
  endtask

  task automatic test_byte_write();
    do_reset();
    run_txn(1'b0, 2'b01, 2'd2, 1'b1, 1, 6, 0);
  endtask

  task automatic test_ram_sel();
    int bad;
    do_reset();
    bad         = 0;
    bus.ram_sel = 1'b0;
    bus.AS20    = 1'b0;
    bus.DS20    = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.DSACK !== 2'b11 || bus.RAS !== 2'b11) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ram_sel_ignore: got %0d active cycles want 0", bad);
    end
    bus.AS20 = 1'b1;
    bus.DS20 = 1'b1;
  endtask

  task automatic test_refresh();
    int le;
    do_reset();
    for (int c = 0; c < 224; c++) begin
      @(negedge clk);
      le = ecnt - 1;
      if (le == DIV - 1) begin
        checks++;
        if (bus.CAS !== 4'hF || bus.RAS !== 2'b11) begin
          errors++; $display("FAIL refresh_early: got RAS %b CAS %b want 11 1111", bus.RAS, bus.CAS);
        end
      end
      if (le == DIV) begin
        checks++;
        if (bus.CAS !== 4'h0 || bus.RAS !== 2'b11) begin
          errors++; $display("FAIL refresh_cas: got RAS %b CAS %b want 11 0000", bus.RAS, bus.CAS);
        end
      end
      if (le == DIV + 1) begin
        checks++;
        if (bus.CAS !== 4'h0 || bus.RAS !== 2'b00) begin
          errors++; $display("FAIL refresh_ras: got RAS %b CAS %b want 00 0000", bus.RAS, bus.CAS);
        end
      end
      if (le == DIV + 3) begin
        checks++;
        if (bus.CAS !== 4'hF || bus.RAS !== 2'b11) begin
          errors++; $display("FAIL refresh_pre: got RAS %b CAS %b want 11 1111", bus.RAS, bus.CAS);
        end
      end
    end
  endtask

  task automatic test_collision();
    do_reset();
    for (int c = 0; c < 300 && ecnt != DIV - 1; c++) @(negedge clk);
    run_txn(1'b1, 2'b00, 2'd0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_overflow();
    do_reset();
    run_txn(1'b1, 2'b00, 2'd0, 1'b0, 2, 0, 4 * DIV + 8);
    checks++;
    if (bus.ref_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: got %b want 1", bus.ref_ovf);
    end
    run_txn(1'b0, 2'b10, 2'd1, 1'b1, 0, 2, 0);
  endtask

  task automatic test_reset_in_ack();
    bit got;
    do_reset();
    got         = 1'b0;
    bus.ram_sel = 1'b1;
    bus.RW20    = 1'b1;
    bus.AS20    = 1'b0;
    bus.DS20    = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.DSACK === 2'b00) got = 1'b1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (!got || bus.RAS !== 2'b11 || bus.CAS !== 4'hF || bus.DSACK !== 2'b11 ||
        bus.RAMOE !== 1'b1 || bus.RAM_MUX !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ack: ack %b RAS %b CAS %b DSACK %b OE %b MUX %b want 1 11 1111 11 1 0",
               got, bus.RAS, bus.CAS, bus.DSACK, bus.RAMOE, bus.RAM_MUX);
    end
    bus.AS20 = 1'b1;
    bus.DS20 = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), $urandom_range(0, 40), $urandom_range(0, 6),
              $urandom_range(0, 3));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_long_read();
    test_byte_write();
    test_ram_sel();
    test_refresh();
    test_collision();
    test_overflow();
    test_reset_in_ack();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
